// File: rtl/laser_point_feeder_if.sv
// Point/result bus between the LASER point feeder and its harness (loader, engine, scorer view).
// master = feeder side, slave = harness/engine side.
interface laser_point_feeder_if;
  logic       load_we;
  logic [5:0] load_addr;
  logic [3:0] load_x;
  logic [3:0] load_y;
  logic       start;
  logic       DUT_RST;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       busy;
  logic       result_valid;
  logic [5:0] covered;
  logic       timeout;
  logic [5:0] exp_cover;
  logic       pass;

  modport master (
    input  load_we, load_addr, load_x, load_y, start, DONE, C1X, C1Y, C2X, C2Y, exp_cover,
    output DUT_RST, X, Y, busy, result_valid, covered, timeout, pass
  );

  modport slave (
    output load_we, load_addr, load_x, load_y, start, DONE, C1X, C1Y, C2X, C2Y, exp_cover,
    input  DUT_RST, X, Y, busy, result_valid, covered, timeout, pass
  );
endinterface

// File: rtl/laser_point_feeder.sv
// Streams a stored point frame into the LASER engine, waits for its two centres and scores coverage.
// Optional LASER_FEEDER_SELFCHECK_EN: pass compares covered against exp_cover.
module laser_point_feeder #(
  parameter int NPTS      = 40,
  parameter int RADIUS_SQ = 16,
  parameter int RST_CYC   = 2,
  parameter int TIMEOUT   = 4095
) (
  input  logic                 CLK,
  input  logic                 RST,
  laser_point_feeder_if.master bus
);

  typedef enum logic [2:0] {IDLE, RSTD, STREAM, WAIT, SCORE, REPORT} state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic [5:0]  acc_q, acc_d;
  logic [5:0]  covered_q, covered_d;
  logic        dut_rst_q, dut_rst_d;
  logic        rv_q, rv_d;
  logic        timeout_q, timeout_d;
  logic        pass_q, pass_d;
  logic [3:0]  x_q, x_d, y_q, y_d;
  logic [3:0]  c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic        hit;

  logic [3:0]  mem_x [NPTS];
  logic [3:0]  mem_y [NPTS];

  // Point memory is deliberately outside reset so a preloaded frame survives an abort.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && bus.load_we && ({1'b0, bus.load_addr} < 7'(NPTS))) begin
      mem_x[bus.load_addr] <= bus.load_x;
      mem_y[bus.load_addr] <= bus.load_y;
    end
  end

  function automatic logic in_circle(input logic [3:0] px, input logic [3:0] py,
                                     input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [7:0] sx, sy;
    logic [8:0] s;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    sx = {4'b0, dx} * {4'b0, dx};
    sy = {4'b0, dy} * {4'b0, dy};
    s  = {1'b0, sx} + {1'b0, sy};
    return s <= 9'(RADIUS_SQ);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    covered_d = covered_q;
    dut_rst_d = dut_rst_q;
    rv_d      = 1'b0;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    x_d       = x_q;
    y_d       = y_q;
    c1x_d     = c1x_q;
    c1y_d     = c1y_q;
    c2x_d     = c2x_q;
    c2y_d     = c2y_q;
    hit       = in_circle(mem_x[idx_q], mem_y[idx_q], c1x_q, c1y_q) |
                in_circle(mem_x[idx_q], mem_y[idx_q], c2x_q, c2y_q);

    unique case (state_q)
      IDLE: begin
        dut_rst_d = 1'b1;
        x_d       = 4'd0;
        y_d       = 4'd0;
        if (bus.start) begin
          state_d   = RSTD;
          cnt_d     = 12'd0;
          covered_d = 6'd0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          if (RST_CYC == 1) begin
            x_d = mem_x[0];
            y_d = mem_y[0];
          end
        end
      end
      RSTD: begin
        if (cnt_q == 12'(RST_CYC - 1)) begin
          state_d   = STREAM;
          idx_d     = 6'd0;
          dut_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 12'd1;
          // Pre-load point 0 so it is on X/Y as the engine leaves reset.
          if (cnt_q == 12'(RST_CYC - 2)) begin
            x_d = mem_x[0];
            y_d = mem_y[0];
          end
        end
      end
      STREAM: begin
        if (idx_q == 6'(NPTS - 1)) begin
          state_d = WAIT;
          cnt_d   = 12'd0;
        end else begin
          idx_d = idx_q + 6'd1;
          x_d   = mem_x[idx_q + 6'd1];
          y_d   = mem_y[idx_q + 6'd1];
        end
      end
      WAIT: begin
        if (bus.DONE) begin
          state_d = SCORE;
          idx_d   = 6'd0;
          acc_d   = 6'd0;
          c1x_d   = bus.C1X;
          c1y_d   = bus.C1Y;
          c2x_d   = bus.C2X;
          c2y_d   = bus.C2Y;
        end else if (cnt_q == 12'(TIMEOUT - 1)) begin
          state_d   = REPORT;
          timeout_d = 1'b1;
          covered_d = 6'd0;
          rv_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      SCORE: begin
        if (idx_q == 6'(NPTS - 1)) begin
          state_d   = REPORT;
          covered_d = acc_q + {5'b0, hit};
          rv_d      = 1'b1;
        end else begin
          acc_d = acc_q + {5'b0, hit};
          idx_d = idx_q + 6'd1;
        end
      end
      REPORT: begin
        state_d   = IDLE;
        dut_rst_d = 1'b1;
        x_d       = 4'd0;
        y_d       = 4'd0;
`ifdef LASER_FEEDER_SELFCHECK_EN
        pass_d = !timeout_q && (covered_q == bus.exp_cover);
`else
        pass_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef LASER_FEEDER_SELFCHECK_EN
  logic unused_exp_cover;
  assign unused_exp_cover = ^bus.exp_cover;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 12'd0;
      idx_q     <= 6'd0;
      acc_q     <= 6'd0;
      covered_q <= 6'd0;
      dut_rst_q <= 1'b1;
      rv_q      <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      c1x_q     <= 4'd0;
      c1y_q     <= 4'd0;
      c2x_q     <= 4'd0;
      c2y_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      covered_q <= covered_d;
      dut_rst_q <= dut_rst_d;
      rv_q      <= rv_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      x_q       <= x_d;
      y_q       <= y_d;
      c1x_q     <= c1x_d;
      c1y_q     <= c1y_d;
      c2x_q     <= c2x_d;
      c2y_q     <= c2y_d;
    end
  end

  assign bus.DUT_RST      = dut_rst_q;
  assign bus.X            = x_q;
  assign bus.Y            = y_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = rv_q;
  assign bus.covered      = covered_q;
  assign bus.timeout      = timeout_q;
  assign bus.pass         = pass_q;

endmodule
